// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller: timed NS/EW phases, all-red clearance,
// latched pedestrian walk phase and flashing-yellow maintenance mode.
module traffic_light_ctrl #(
  parameter int CNT_W          = 8,
  parameter int GREEN_CYCLES   = 20,
  parameter int YELLOW_CYCLES  = 4,
  parameter int ALL_RED_CYCLES = 2,
  parameter int PED_CYCLES     = 10,
  parameter int FLASH_HALF     = 8
) (
  input  logic             clk,
  input  logic             asyn_n_reset,
  input  logic             enable,
  input  logic             flash_mode,
  input  logic             ped_req,
  output logic [1:0]       ns_light,
  output logic [1:0]       ew_light,
  output logic             ped_walk,
  output logic             ped_pending,
  output logic [CNT_W-1:0] phase_cnt,
  output logic [2:0]       state_dbg
);

  // Lamp codes shared with the lamp drivers.
  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;
  localparam logic [1:0] LAMP_OFF    = 2'b11;

  localparam int MAX_DUR = (2 ** CNT_W) - 1;

  if (GREEN_CYCLES < 1 || GREEN_CYCLES > MAX_DUR ||
      YELLOW_CYCLES < 1 || YELLOW_CYCLES > MAX_DUR ||
      ALL_RED_CYCLES < 1 || ALL_RED_CYCLES > MAX_DUR ||
      PED_CYCLES < 1 || PED_CYCLES > MAX_DUR ||
      FLASH_HALF < 1 || FLASH_HALF > MAX_DUR) begin : g_bad_duration
    $error("traffic_light_ctrl: every duration must lie in 1..2**CNT_W-1");
  end

  typedef enum logic [2:0] {
    NS_GREEN, NS_YELLOW, ALL_RED_1, EW_GREEN,
    EW_YELLOW, ALL_RED_2, PED_WALK, FLASH
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt, last_cnt;
  logic             flash_tog, flash_tog_nxt, ped_pending_nxt;

  assign state_dbg = state;

  // Final phase_cnt value of the current phase; in FLASH it marks a half-period.
  always_comb begin
    last_cnt = CNT_W'(GREEN_CYCLES - 1);
    case (state)
      NS_GREEN, EW_GREEN:   last_cnt = CNT_W'(GREEN_CYCLES - 1);
      NS_YELLOW, EW_YELLOW: last_cnt = CNT_W'(YELLOW_CYCLES - 1);
      ALL_RED_1, ALL_RED_2: last_cnt = CNT_W'(ALL_RED_CYCLES - 1);
      PED_WALK:             last_cnt = CNT_W'(PED_CYCLES - 1);
      FLASH:                last_cnt = CNT_W'(FLASH_HALF - 1);
      default:              last_cnt = CNT_W'(GREEN_CYCLES - 1);
    endcase
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = phase_cnt;
    flash_tog_nxt = flash_tog;
    if (flash_mode) begin
      // Flash overrides enable; the toggle keeps running while frozen.
      if (state == FLASH) begin
        if (phase_cnt == last_cnt) begin
          cnt_nxt       = '0;
          flash_tog_nxt = ~flash_tog;
        end else begin
          cnt_nxt = phase_cnt + CNT_W'(1);
        end
      end else begin
        state_nxt     = FLASH;
        cnt_nxt       = '0;
        flash_tog_nxt = 1'b1;
      end
    end else if (state == FLASH) begin
      state_nxt = ALL_RED_2;
      cnt_nxt   = '0;
    end else if (enable) begin
      if (phase_cnt == last_cnt) begin
        cnt_nxt = '0;
        case (state)
          NS_GREEN:  state_nxt = NS_YELLOW;
          NS_YELLOW: state_nxt = ALL_RED_1;
          ALL_RED_1: state_nxt = EW_GREEN;
          EW_GREEN:  state_nxt = EW_YELLOW;
          EW_YELLOW: state_nxt = ALL_RED_2;
          // A request landing on the last all-red cycle is served right away.
          ALL_RED_2: state_nxt = (ped_pending | ped_req) ? PED_WALK : NS_GREEN;
          PED_WALK:  state_nxt = NS_GREEN;
          default:   state_nxt = NS_GREEN;
        endcase
      end else begin
        cnt_nxt = phase_cnt + CNT_W'(1);
      end
    end
    ped_pending_nxt = (ped_pending | ped_req) & (state_nxt != PED_WALK);
  end

  always_ff @(posedge clk or negedge asyn_n_reset) begin
    if (!asyn_n_reset) begin
      state       <= NS_GREEN;
      phase_cnt   <= '0;
      flash_tog   <= 1'b1;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase_cnt   <= cnt_nxt;
      flash_tog   <= flash_tog_nxt;
      ped_pending <= ped_pending_nxt;
    end
  end

  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    ped_walk = 1'b0;
    case (state)
      NS_GREEN:  ns_light = LAMP_GREEN;
      NS_YELLOW: ns_light = LAMP_YELLOW;
      EW_GREEN:  ew_light = LAMP_GREEN;
      EW_YELLOW: ew_light = LAMP_YELLOW;
      PED_WALK:  ped_walk = 1'b1;
      FLASH: begin
        ns_light = flash_tog ? LAMP_YELLOW : LAMP_OFF;
        ew_light = flash_tog ? LAMP_YELLOW : LAMP_OFF;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed scenarios plus random
// stimulus, compared against a phase-table reference model.
module tb_traffic_light_ctrl;

  localparam int CNT_W = 4;
  localparam logic [1:0] R = 2'b00, Y = 2'b01, G = 2'b10, OFF = 2'b11;

  logic             clk = 1'b0;
  logic             asyn_n_reset;
  logic             enable, flash_mode, ped_req;
  logic [1:0]       ns_light, ew_light;
  logic             ped_walk, ped_pending;
  logic [CNT_W-1:0] phase_cnt;
  logic [2:0]       state_dbg;

  traffic_light_ctrl #(
    .CNT_W(CNT_W), .GREEN_CYCLES(4), .YELLOW_CYCLES(2), .ALL_RED_CYCLES(1),
    .PED_CYCLES(3), .FLASH_HALF(2)
  ) dut (
    .clk(clk), .asyn_n_reset(asyn_n_reset), .enable(enable),
    .flash_mode(flash_mode), .ped_req(ped_req), .ns_light(ns_light),
    .ew_light(ew_light), .ped_walk(ped_walk), .ped_pending(ped_pending),
    .phase_cnt(phase_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // Phases in cycle order: 0 NS green, 1 NS yellow, 2 all-red, 3 EW green,
  // 4 EW yellow, 5 all-red, 6 walk, 7 flash.
  int         dur[8] = '{4, 2, 1, 4, 2, 1, 3, 2};
  logic [1:0] ns_tab[7] = '{G, Y, R, R, R, R, R};
  logic [1:0] ew_tab[7] = '{R, R, R, G, Y, R, R};
  int         m_ph, m_cnt;
  bit         m_tog, m_pp;

  logic [9:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [9:0] model_word();
    logic [1:0] ns, ew;
    if (m_ph == 7) begin
      ns = m_tog ? Y : OFF;
      ew = ns;
    end else begin
      ns = ns_tab[m_ph];
      ew = ew_tab[m_ph];
    end
    return {ns, ew, (m_ph == 6), m_pp, 4'(m_cnt)};
  endfunction

  function automatic void model_reset();
    m_ph = 0; m_cnt = 0; m_tog = 1'b1; m_pp = 1'b0;
  endfunction

  function automatic void model_step(bit en, bit fm, bit pr);
    int nph  = m_ph;
    int ncnt = m_cnt;
    bit ntog = m_tog;
    if (fm) begin
      if (m_ph == 7) begin
        ncnt = m_cnt + 1;
        if (ncnt == dur[7]) begin ncnt = 0; ntog = !m_tog; end
      end else begin
        nph = 7; ncnt = 0; ntog = 1'b1;
      end
    end else if (m_ph == 7) begin
      nph = 5; ncnt = 0;
    end else if (en) begin
      ncnt = m_cnt + 1;
      if (ncnt == dur[m_ph]) begin
        ncnt = 0;
        if (m_ph == 5)      nph = (m_pp || pr) ? 6 : 0;
        else if (m_ph == 6) nph = 0;
        else                nph = m_ph + 1;
      end
    end
    m_pp  = (m_pp || pr) && (nph != 6);
    m_ph  = nph;
    m_cnt = ncnt;
    m_tog = ntog;
    exp_q.push_back(model_word());
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    logic [9:0] e;
    if (exp_q.size() == 0) e = model_word();
    else e = exp_q.pop_front();
    chk({tag, "_ns"},  32'(ns_light),    32'(e[9:8]));
    chk({tag, "_ew"},  32'(ew_light),    32'(e[7:6]));
    chk({tag, "_walk"}, 32'(ped_walk),   32'(e[5]));
    chk({tag, "_pend"}, 32'(ped_pending), 32'(e[4]));
    chk({tag, "_cnt"}, 32'(phase_cnt),   32'(e[3:0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input string tag);
    @(posedge clk);
    model_step(enable, flash_mode, ped_req);
    #1;
    check_model(tag);
  endtask

  task automatic advance_to(input int ph, input int cnt, input string tag);
    int n = 0;
    while (!(m_ph == ph && m_cnt == cnt) && n < 60) begin
      tick(tag);
      n++;
    end
    chk({tag, "_reached"}, 32'(m_ph == ph && m_cnt == cnt), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int seq1[14] = '{0, 1, 2, 3, 0, 1, 0, 0, 1, 2, 3, 0, 1, 0};

  initial begin
    int  walks;
    bit  was_walk;
    asyn_n_reset = 1'b0;
    enable = 1'b0; flash_mode = 1'b0; ped_req = 1'b0;
    model_reset();
    #1;
    chk("rst_ns", 32'(ns_light), 32'(G));
    chk("rst_ew", 32'(ew_light), 32'(R));
    chk("rst_walk", 32'(ped_walk), 0);
    chk("rst_cnt", 32'(phase_cnt), 0);
    #22;
    asyn_n_reset = 1'b1;
    enable = 1'b1;
    check_model("rel");

    // 1: free-running cycle, 14-cycle period
    chk("p1_cnt", 32'(phase_cnt), 32'(seq1[0]));
    for (int k = 1; k <= 28; k++) begin
      tick("p1");
      chk("p1_cnt", 32'(phase_cnt), 32'(seq1[k % 14]));
      chk("p1_ns", 32'(ns_light), 32'((k % 14) < 4 ? G : ((k % 14) < 6 ? Y : R)));
    end

    // 2: single ped pulse during EW green
    for (int k = 0; k < 7; k++) tick("p2a");
    chk("p2_ew_green", 32'(ew_light), 32'(G));
    ped_req = 1'b1;
    tick("p2b");
    ped_req = 1'b0;
    chk("p2_pending", 32'(ped_pending), 1);
    walks = 0;
    for (int k = 0; k < 20; k++) begin
      tick("p2c");
      if (ped_walk) begin
        walks++;
        chk("p2_walk_ns", 32'(ns_light), 32'(R));
        chk("p2_walk_ew", 32'(ew_light), 32'(R));
        chk("p2_walk_pend", 32'(ped_pending), 0);
      end
    end
    chk("p2_walk_len", 32'(walks), 3);

    // 3: freeze mid NS green
    advance_to(0, 2, "p3a");
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick("p3b");
      chk("p3_hold_cnt", 32'(phase_cnt), 2);
      chk("p3_hold_ns", 32'(ns_light), 32'(G));
    end
    enable = 1'b1;
    tick("p3c");
    chk("p3_green_last", 32'(ns_light), 32'(G));
    tick("p3d");
    chk("p3_yellow", 32'(ns_light), 32'(Y));

    // 4: flash entry during EW green, ped request in flash
    advance_to(3, 1, "p4a");
    flash_mode = 1'b1;
    tick("p4b"); chk("p4_y0", 32'({ns_light, ew_light}), 32'({Y, Y}));
    ped_req = 1'b1;
    enable = 1'b0;
    tick("p4c"); chk("p4_y1", 32'({ns_light, ew_light}), 32'({Y, Y}));
    ped_req = 1'b0;
    tick("p4d"); chk("p4_off0", 32'({ns_light, ew_light}), 32'({OFF, OFF}));
    enable = 1'b1;
    tick("p4e"); chk("p4_off1", 32'({ns_light, ew_light}), 32'({OFF, OFF}));
    tick("p4f"); chk("p4_y2", 32'({ns_light, ew_light}), 32'({Y, Y}));
    chk("p4_pend", 32'(ped_pending), 1);
    flash_mode = 1'b0;
    tick("p4g"); chk("p4_allred", 32'({ns_light, ew_light, ped_walk}), 32'({R, R, 1'b0}));
    for (int k = 0; k < 3; k++) begin
      tick("p4h"); chk("p4_walk", 32'(ped_walk), 1);
    end
    tick("p4i"); chk("p4_nsg", 32'(ns_light), 32'(G));

    // 5: asynchronous reset during EW yellow with a pending request
    advance_to(3, 3, "p5a");
    ped_req = 1'b1;
    tick("p5b");
    ped_req = 1'b0;
    chk("p5_in_ew_yellow", 32'(ew_light), 32'(Y));
    chk("p5_pend_set", 32'(ped_pending), 1);
    #2;
    asyn_n_reset = 1'b0;
    #1;
    chk("p5_ns", 32'(ns_light), 32'(G));
    chk("p5_ew", 32'(ew_light), 32'(R));
    chk("p5_walk", 32'(ped_walk), 0);
    chk("p5_pend", 32'(ped_pending), 0);
    chk("p5_cnt", 32'(phase_cnt), 0);
    model_reset();
    #2;
    asyn_n_reset = 1'b1;

    // 6: ped_req held high
    ped_req = 1'b1;
    walks = 0;
    was_walk = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick("p6");
      if (ped_walk) chk("p6_walk_pend", 32'(ped_pending), 0);
      else if (was_walk) begin
        walks++;
        chk("p6_after_walk_pend", 32'(ped_pending), 1);
      end
      was_walk = ped_walk;
    end
    chk("p6_walks", 32'(walks >= 2), 1);
    ped_req = 1'b0;

    // 7: randomized stimulus against the model
    for (int k = 0; k < 400; k++) begin
      enable  = ($urandom_range(0, 9) != 0);
      ped_req = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 24) == 0) flash_mode = !flash_mode;
      tick("rnd");
    end
    flash_mode = 1'b0;
    for (int k = 0; k < 20; k++) tick("tail");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
